vga_line_prefetch: RTL
======================

Name: vga_line_prefetch

Overview:
- Sits directly upstream of the graphic generator in the VGA path. It takes the x/y pixel coordinates from the VGA timing controller and delivers the 8-bit pixel byte that the generator consumes as its RAM data.
- It reads a low-resolution framebuffer (IMG_W x IMG_H bytes) through a pipelined in-order memory read port. It prefetches one image row ahead into a ping-pong line buffer.
- Each image pixel is upscaled by 2^SCALE_LOG2 in both axes.

Parameters:
- IMG_W, 160, image row length in bytes.
- IMG_H, 120, image row count.
- SCALE_LOG2, 2, log2 of the upscale factor (4x4 screen pixels per image pixel).
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, total lines per frame.
- ADDR_W, 15, memory address width (must satisfy 2^ADDR_W >= IMG_W*IMG_H).
- MAX_OUT, 4, maximum outstanding memory reads.

Ports:
- clk  in  1  pixel clock (the vgaclk domain).
- rst  in  1  synchronous, active-high reset.
- x  in  10  current column from the timing controller.
- y  in  10  current line from the timing controller.
- mem_req  out  1  read request valid.
- mem_ready  in  1  a request is accepted when mem_req && mem_ready.
- mem_addr  out  ADDR_W  byte address, computed as row*IMG_W + col.
- mem_rvalid  in  1  read data valid; responses return in request order, at least 1 cycle after acceptance.
- mem_rdata  in  8  read data.
- pixel_data  out  8  pixel byte to the graphic generator.
- fetch_busy  out  1  a row fetch is in progress.
- underrun  out  1  sticky flag: a row was displayed before its fetch completed.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - pixel_data = 0, mem_req = 0, mem_addr = 0, fetch_busy = 0, underrun = 0.
  - FSM in IDLE; outstanding count = 0; both line-buffer banks marked not ready.
  - Line-buffer contents are not cleared.
- Pixel path:
  - Image row r = y >> SCALE_LOG2, column c = x >> SCALE_LOG2; bank = r[0].
  - pixel_data is registered: 1-cycle latency from x/y to the pixel.
  - If x >= H_ACTIVE, y >= V_ACTIVE, c >= IMG_W or r >= IMG_H, the output is 0.
- Fetch triggers, sampled when x == 0:
  - y == V_TOTAL-1: fetch row 0 into bank 0.
  - y == (r << SCALE_LOG2) with r <= IMG_H-2: fetch row r+1 into bank (r+1)[0].
  - At most one trigger per line.
- FSM states:
  - IDLE: on a trigger, latch the target row and bank, clear the bank-ready bit, reset the request column and write pointer to 0, set fetch_busy, and go to REQ.
  - REQ: assert mem_req whenever outstanding < MAX_OUT. mem_addr = row*IMG_W + req_col. Each accepted request increments req_col and outstanding. When req_col reaches IMG_W after acceptance, go to DRAIN.
  - DRAIN: wait until all IMG_W bytes are written, then set the bank-ready bit, clear fetch_busy and go to IDLE.
- Response handling, in every state:
  - On mem_rvalid with outstanding > 0, write mem_rdata to bank[wptr], increment wptr, decrement outstanding.
  - If an acceptance and a response occur in the same cycle, outstanding is unchanged.
  - mem_rvalid while outstanding == 0 is ignored. This covers stray responses after reset mid-fetch.
- Trigger while busy (previous fetch unfinished): the trigger is ignored; the current fetch continues.
- Underrun:
  - Set when the active display of row r begins (x == 0, y == r << SCALE_LOG2, y < V_ACTIVE) while bank r[0] is not ready.
  - Cleared only by rst.
  - The displayed bytes are then whatever the bank holds (no stall).
- Address arithmetic: the row base is accumulated by adding IMG_W per row (no multiplier). It wraps at ADDR_W and stays within range by the parameter constraint.
- Wrap-around: row IMG_H-1 has no next-row trigger. The next fetch is row 0 at y == V_TOTAL-1.

Test Plan:
- Memory model with ready = 1 and 3-cycle in-order latency; run a full frame -> row 0 fetch starts at y = 524, x = 0, and issues addresses 0..159. At y = 0, x = 8, pixel_data equals mem[2] one cycle later. underrun stays 0.
- Data = low byte of the address; y = 4..7, x = 0..3 -> pixel_data = 160 (row 1, col 0). At x = 636 -> 159+160 = 319, low byte 0x3F.
- mem_ready toggling 1/0 and latency 6 -> mem_req never has more than 4 requests outstanding. All 160 bytes land in order; fetch_busy falls only after the 160th rvalid.
- Memory stalled (ready = 0) for 5000 cycles during the row 1 fetch -> underrun = 1 at y = 4, x = 0, and remains 1 until rst.
- rst asserted mid-REQ with 2 reads outstanding, then 2 stray rvalids -> outputs return to reset values, stray data is not written, and the next fetch at y = 524 completes correctly.
- x = 700 or y = 500 -> pixel_data = 0.

Source files
------------

// File: rtl/vga_line_prefetch.sv
// Prefetches one low-resolution image row ahead into a ping-pong line buffer and
// delivers the upscaled pixel byte for the current x/y to the graphic generator.
module vga_line_prefetch #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SCALE_LOG2 = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525,
  parameter int ADDR_W     = 15,
  parameter int MAX_OUT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pixel_data,
  output logic              fetch_busy,
  output logic              underrun,
  output logic [1:0]        dbg_state
);

  // Memory port: a request transfers on any cycle with mem_req && mem_ready; mem_addr
  // holds until then. Responses return in request order, one byte per mem_rvalid.

  localparam int RW = 10 - SCALE_LOG2;
  localparam int CW = $clog2(IMG_W + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int LW = $clog2(2 * IMG_W);

  localparam logic [9:0]        SUB_MASK  = 10'((1 << SCALE_LOG2) - 1);
  localparam logic [9:0]        V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]        H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]        V_ACT     = 10'(V_ACTIVE);
  localparam logic [RW-1:0]     IMG_W_C   = RW'(IMG_W);
  localparam logic [RW-1:0]     IMG_H_C   = RW'(IMG_H);
  localparam logic [RW-1:0]     TRIG_MAX  = RW'(IMG_H - 2);
  localparam logic [CW-1:0]     ROW_LEN   = CW'(IMG_W);
  localparam logic [CW-1:0]     ROW_LAST  = CW'(IMG_W - 1);
  localparam logic [OW-1:0]     OUT_MAX   = OW'(MAX_OUT);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(IMG_W);
  localparam logic [LW-1:0]     BANK1_OFS = LW'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     out_cnt_q;
  logic [CW-1:0]     req_col_q;
  logic [CW-1:0]     wptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] next_base_q;
  logic              bank_q;
  logic [1:0]        bank_rdy_q;
  logic              underrun_q;
  logic [7:0]        pixel_q;
  logic [7:0]        line_buf_q [2*IMG_W];

  logic [RW-1:0] row_w;
  logic [RW-1:0] col_w;
  logic          line_start;
  logic          row_line;
  logic          trig_row0;
  logic          trig_next;
  logic          trigger;
  logic          trig_bank;
  logic          start;
  logic          disp_start;
  logic          pix_ok;
  logic          accept;
  logic          resp;
  logic          fetch_done;
  logic [LW-1:0] wr_idx;
  logic [LW-1:0] rd_idx;

  assign row_w      = y[9:SCALE_LOG2];
  assign col_w      = x[9:SCALE_LOG2];
  assign line_start = (x == 10'd0);
  assign row_line   = ((y & SUB_MASK) == 10'd0);
  assign trig_row0  = line_start && (y == V_LAST);
  assign trig_next  = line_start && row_line && (row_w <= TRIG_MAX) && !trig_row0;
  assign trigger    = trig_row0 || trig_next;
  assign trig_bank  = trig_row0 ? 1'b0 : ~row_w[0];
  assign start      = (state_q == S_IDLE) && trigger;
  assign disp_start = line_start && row_line && (y < V_ACT) && (row_w < IMG_H_C);
  assign pix_ok     = (x < H_ACT) && (y < V_ACT) && (col_w < IMG_W_C) && (row_w < IMG_H_C);
  assign accept     = mem_req && mem_ready;
  // Responses with nothing outstanding are strays (e.g. from before a reset).
  assign resp       = mem_rvalid && (out_cnt_q != '0);
  assign fetch_done = (wptr_q == ROW_LEN);
  assign wr_idx     = bank_q   ? BANK1_OFS + LW'(wptr_q) : LW'(wptr_q);
  assign rd_idx     = row_w[0] ? BANK1_OFS + LW'(col_w)  : LW'(col_w);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (trigger) state_d = S_REQ;
      S_REQ:   if (accept && (req_col_q == ROW_LAST)) state_d = S_DRAIN;
      S_DRAIN: if (fetch_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    fetch_busy = 1'b0;
    unique case (state_q)
      S_REQ: begin
        mem_req    = (out_cnt_q < OUT_MAX);
        fetch_busy = 1'b1;
      end
      S_DRAIN: fetch_busy = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state  = state_q;
  assign mem_addr   = addr_q;
  assign pixel_data = pixel_q;
  assign underrun   = underrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_q   <= '0;
      req_col_q   <= '0;
      wptr_q      <= '0;
      addr_q      <= '0;
      next_base_q <= ADDR_STEP;
      bank_q      <= 1'b0;
      bank_rdy_q  <= 2'b00;
      underrun_q  <= 1'b0;
      pixel_q     <= 8'd0;
    end else begin
      if (accept && !resp)      out_cnt_q <= out_cnt_q + OW'(1);
      else if (!accept && resp) out_cnt_q <= out_cnt_q - OW'(1);

      if (start) begin
        bank_q                <= trig_bank;
        addr_q                <= trig_row0 ? '0 : next_base_q;
        req_col_q             <= '0;
        wptr_q                <= '0;
        bank_rdy_q[trig_bank] <= 1'b0;
      end else begin
        if (accept) begin
          req_col_q <= req_col_q + CW'(1);
          addr_q    <= addr_q + ADDR_W'(1);
        end
        if (resp) wptr_q <= wptr_q + CW'(1);
        if ((state_q == S_DRAIN) && fetch_done) bank_rdy_q[bank_q] <= 1'b1;
      end

      // Row base tracks every row-start line, even when that line's fetch is dropped.
      if (trig_row0)      next_base_q <= ADDR_STEP;
      else if (trig_next) next_base_q <= next_base_q + ADDR_STEP;

      if (disp_start && !bank_rdy_q[row_w[0]]) underrun_q <= 1'b1;

      pixel_q <= pix_ok ? line_buf_q[rd_idx] : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && resp) line_buf_q[wr_idx] <= mem_rdata;
  end

endmodule
